// File: rtl/move_commit_ctrl_if.sv
// Move-request and board-RAM signal bundle for move_commit_ctrl.
// master: request source / RAM side; slave: the commit controller.
interface move_commit_ctrl_if #(
   parameter int COORD_W = 4,
   parameter int ADDR_W  = 8,
   parameter int CNT_W   = 9
);
   logic               req_valid;
   logic [COORD_W-1:0] req_x;
   logic [COORD_W-1:0] req_y;
   logic               req_ready;
   logic [ADDR_W-1:0]  mem_addr;
   logic [1:0]         mem_rdata;
   logic [1:0]         mem_wdata;
   logic               mem_we;
   logic               done;
   logic               accepted;
   logic [1:0]         reject_code;
   logic               turn;
   logic [CNT_W-1:0]   move_count;
   logic               board_full;

   modport master (
      output req_valid, req_x, req_y, mem_rdata,
      input  req_ready, mem_addr, mem_wdata, mem_we, done, accepted,
             reject_code, turn, move_count, board_full
   );

   modport slave (
      input  req_valid, req_x, req_y, mem_rdata,
      output req_ready, mem_addr, mem_wdata, mem_we, done, accepted,
             reject_code, turn, move_count, board_full
   );
endinterface

// File: rtl/move_commit_ctrl.sv
// Commits a player's move into board RAM when the target cell is empty,
// reports the outcome, alternates the turn and counts placed stones.
//
// state | meaning
// IDLE  | ready for a request
// RD    | cell address presented, RAM is reading it
// CHK   | cell contents inspected
// WR    | stone written (one-cycle mem_we)
// RESP  | result valid, done pulse
module move_commit_ctrl #(
   parameter int BOARD_W = 16,
   parameter int BOARD_H = 16,
   parameter int COORD_W = 4,
   parameter int ADDR_W  = 8,
   parameter int CNT_W   = 9
) (
   input  logic clk,
   input  logic reset,
   move_commit_ctrl_if.slave bus
);
   localparam int CELLS = BOARD_W * BOARD_H;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_CHK, S_WR, S_RESP} state_t;

   state_t            state;
   logic              req_oor;
   logic [ADDR_W-1:0] req_addr;

   // Range check and linear address of the incoming request.
   always_comb begin
      req_oor  = (int'(bus.req_x) >= BOARD_W) || (int'(bus.req_y) >= BOARD_H);
      req_addr = ADDR_W'(int'(bus.req_y) * BOARD_W + int'(bus.req_x));
   end

   // Request sequencing with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         bus.req_ready    <= 1'b1;
         bus.mem_addr     <= '0;
         bus.mem_wdata    <= 2'b00;
         bus.mem_we       <= 1'b0;
         bus.done         <= 1'b0;
         bus.accepted     <= 1'b0;
         bus.reject_code  <= 2'b00;
         bus.turn         <= 1'b0;
         bus.move_count   <= '0;
         bus.board_full   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  bus.req_ready <= 1'b0;
                  if (bus.board_full) begin
                     state           <= S_RESP;
                     bus.done        <= 1'b1;
                     bus.accepted    <= 1'b0;
                     bus.reject_code <= 2'b11;
                  end else if (req_oor) begin
                     state           <= S_RESP;
                     bus.done        <= 1'b1;
                     bus.accepted    <= 1'b0;
                     bus.reject_code <= 2'b01;
                  end else begin
                     state        <= S_RD;
                     bus.mem_addr <= req_addr;
                  end
               end
            end
            S_RD: state <= S_CHK;
            S_CHK: begin
               // Reserved code 11 is treated as occupied too.
               if (bus.mem_rdata != 2'b00) begin
                  state           <= S_RESP;
                  bus.done        <= 1'b1;
                  bus.accepted    <= 1'b0;
                  bus.reject_code <= 2'b10;
               end else begin
                  state         <= S_WR;
                  bus.mem_we    <= 1'b1;
                  bus.mem_wdata <= bus.turn ? 2'b10 : 2'b01;
               end
            end
            S_WR: begin
               state           <= S_RESP;
               bus.mem_we      <= 1'b0;
               bus.done        <= 1'b1;
               bus.accepted    <= 1'b1;
               bus.reject_code <= 2'b00;
            end
            S_RESP: begin
               state         <= S_IDLE;
               bus.done      <= 1'b0;
               bus.req_ready <= 1'b1;
               if (bus.accepted && !bus.board_full) begin
                  bus.turn       <= ~bus.turn;
                  bus.move_count <= bus.move_count + CNT_W'(1);
                  bus.board_full <= (bus.move_count + CNT_W'(1)) == CNT_W'(CELLS);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_move_commit_ctrl.sv
// Bench for move_commit_ctrl: directed scenarios with literal expectations
// plus a randomized phase, all outputs compared each cycle with a
// transaction-level model of the move protocol.
module tb_move_commit_ctrl;
   localparam int CW = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   move_commit_ctrl_if #(.COORD_W(CW), .ADDR_W(8), .CNT_W(9)) bus ();

   move_commit_ctrl #(
      .BOARD_W(16), .BOARD_H(16), .COORD_W(CW), .ADDR_W(8), .CNT_W(9)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [1:0] ram [256];
   logic [1:0] mdl_board [256];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Board RAM: one-cycle read latency, synchronous write.
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   // Transaction model: on a handshake, derive the full schedule of the
   // request from the board contents, the move count and the turn.
   bit         armed = 0;
   int         c = 0;
   bit         pend = 0;
   int         t_done, t_we;
   bit         m_acc, m_mem, m_turn;
   logic [1:0] m_code, m_wd;
   logic [7:0] m_addr;
   int         m_cnt = 0;
   bit         hold_acc = 0;
   logic [1:0] hold_code = 2'b00;
   int         mx, my;
   bit         now_done;

   // Per-cycle comparison against the model, then advance it across the edge.
   always @(negedge clk) begin
      now_done = pend && (c == t_done);
      if (armed) begin
         chk("req_ready", bus.req_ready, !pend);
         chk("mem_we", bus.mem_we, pend && (c == t_we));
         if (pend && (c == t_we)) chk("mem_wdata", bus.mem_wdata, m_wd);
         if (pend && m_mem && (c < t_done)) chk("mem_addr", bus.mem_addr, m_addr);
         chk("done", bus.done, now_done);
         chk("accepted", bus.accepted, now_done ? m_acc : hold_acc);
         chk("reject_code", bus.reject_code, now_done ? m_code : hold_code);
         chk("turn", bus.turn, m_turn);
         chk("move_count", bus.move_count, m_cnt);
         chk("board_full", bus.board_full, m_cnt == 256);
      end
      if (pend && (c == t_we)) mdl_board[m_addr] = m_wd;
      if (reset) begin
         armed = 1; pend = 0; m_turn = 0; m_cnt = 0; hold_acc = 0; hold_code = 2'b00;
      end else if (now_done) begin
         hold_acc = m_acc; hold_code = m_code;
         if (m_acc) begin m_turn = !m_turn; m_cnt++; end
         pend = 0;
      end else if (armed && !pend && bus.req_valid) begin
         mx = int'(bus.req_x); my = int'(bus.req_y);
         pend = 1; t_we = -1; m_acc = 0; m_mem = 0;
         if (m_cnt == 256) begin
            m_code = 2'b11; t_done = c + 1;
         end else if (mx >= 16 || my >= 16) begin
            m_code = 2'b01; t_done = c + 1;
         end else begin
            m_mem = 1; m_addr = 8'(my * 16 + mx);
            if (mdl_board[m_addr] != 2'b00) begin
               m_code = 2'b10; t_done = c + 3;
            end else begin
               m_code = 2'b00; m_acc = 1; t_we = c + 3; t_done = c + 4;
               m_wd = m_turn ? 2'b10 : 2'b01;
            end
         end
      end
      c++;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      tick(); reset = 1; bus.req_valid = 0;
      tick(); reset = 0;
   endtask

   task automatic clear_board();
      for (int i = 0; i < 256; i++) begin ram[i] = 2'b00; mdl_board[i] = 2'b00; end
   endtask

   // Present a request and return once it has been taken (now in cycle N+1).
   task automatic handshake(input int x, input int y);
      bit hs;
      hs = 0;
      tick();
      bus.req_valid = 1; bus.req_x = CW'(x); bus.req_y = CW'(y);
      for (int i = 0; i < 20 && !hs; i++) begin
         @(negedge clk);
         if (bus.req_ready) hs = 1; else @(posedge clk);
      end
      chk("handshake_taken", hs, 1);
      @(posedge clk); #1;
      bus.req_valid = 0;
   endtask

   task automatic req(input int x, input int y, output int lat, output bit saw_we,
                      output logic [7:0] a, output logic [1:0] wd);
      handshake(x, y);
      lat = 0; saw_we = 0; a = 8'h00; wd = 2'b00;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge clk);
         if (bus.mem_we) begin saw_we = 1; a = bus.mem_addr; wd = bus.mem_wdata; end
         if (bus.done) lat = i; else @(posedge clk);
      end
   endtask

   task automatic reset_mid(input int stage);
      bit quiet;
      ram[8'h97] = 2'b00; mdl_board[8'h97] = 2'b00;
      handshake(7, 9);
      if (stage == 2) tick();
      reset = 1; tick(); reset = 0;
      quiet = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.mem_we || bus.done) quiet = 0;
         @(posedge clk);
      end
      #1;
      chk("reset_mid_quiet", quiet, 1);
      chk("reset_mid_turn", bus.turn, 0);
      chk("reset_mid_count", bus.move_count, 0);
      chk("reset_mid_ready", bus.req_ready, 1);
      chk("reset_mid_code", bus.reject_code, 0);
   endtask

   int lat, ndone;
   bit saw;
   logic [7:0] a;
   logic [1:0] wd;

   initial begin
      bus.req_valid = 0; bus.req_x = '0; bus.req_y = '0; bus.mem_rdata = 2'b00;
      clear_board();
      reset = 1; tick(); tick(); reset = 0;
      @(negedge clk);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_done", bus.done, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_turn", bus.turn, 0);
      chk("rst_count", bus.move_count, 0);

      // First move: empty cell accepted, black stone.
      req(3, 5, lat, saw, a, wd);
      chk("t1_lat", lat, 4); chk("t1_we", saw, 1); chk("t1_addr", a, 8'h53);
      chk("t1_wdata", wd, 2'b01); chk("t1_acc", bus.accepted, 1); chk("t1_code", bus.reject_code, 0);
      tick();
      chk("t1_turn", bus.turn, 1); chk("t1_count", bus.move_count, 1);

      // Same cell again: occupied.
      req(3, 5, lat, saw, a, wd);
      chk("t2_lat", lat, 3); chk("t2_we", saw, 0);
      chk("t2_acc", bus.accepted, 0); chk("t2_code", bus.reject_code, 2'b10);
      tick();
      chk("t2_turn", bus.turn, 1); chk("t2_count", bus.move_count, 1);

      // Out of range column.
      req(16, 2, lat, saw, a, wd);
      chk("t3_lat", lat, 1); chk("t3_we", saw, 0); chk("t3_code", bus.reject_code, 2'b01);
      @(negedge clk);
      chk("t3_ready_back", bus.req_ready, 1);

      // Reset in RD and in CHK, then a normal first move.
      reset_mid(1);
      reset_mid(2);
      ram[8'h53] = 2'b00; mdl_board[8'h53] = 2'b00;
      req(3, 5, lat, saw, a, wd);
      chk("t5_lat", lat, 4); chk("t5_addr", a, 8'h53); chk("t5_wdata", wd, 2'b01);

      // req_valid held high: one handshake per finished transaction.
      repeat (3) tick();
      bus.req_valid = 1; bus.req_x = CW'(16); bus.req_y = CW'(0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); if (bus.done) ndone++;
         @(posedge clk);
      end
      #1; bus.req_valid = 0;
      chk("t6_oor_dones", ndone, 20);
      repeat (3) tick();
      bus.req_valid = 1; bus.req_x = CW'(3); bus.req_y = CW'(5);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); if (bus.done) ndone++;
         @(posedge clk);
      end
      #1; bus.req_valid = 0;
      chk("t6_occ_dones", ndone, 10);

      // Randomized traffic with occasional resets.
      repeat (6) tick();
      for (int i = 0; i < 256; i++) begin
         wd = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         ram[i] = wd; mdl_board[i] = wd;
      end
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         tick();
         reset = ($urandom_range(0, 59) == 0);
         bus.req_valid = ($urandom_range(0, 9) < 7);
         bus.req_x = CW'($urandom_range(0, 17));
         bus.req_y = CW'($urandom_range(0, 17));
      end
      tick(); reset = 0; bus.req_valid = 0;

      // Fill the whole board, then a full-board reject.
      clear_board();
      do_reset();
      for (int i = 0; i < 256; i++) begin
         req(i % 16, i / 16, lat, saw, a, wd);
         chk("t4_lat", lat, 4);
         chk("t4_wdata", wd, (i % 2) ? 2'b10 : 2'b01);
      end
      tick();
      chk("t4_full", bus.board_full, 1); chk("t4_count", bus.move_count, 256);
      req(0, 0, lat, saw, a, wd);
      chk("t4_full_lat", lat, 1); chk("t4_full_we", saw, 0); chk("t4_full_code", bus.reject_code, 2'b11);
      req(16, 0, lat, saw, a, wd);
      chk("t4_full_prio", bus.reject_code, 2'b11);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
